csr_access_ctrl: RTL and testbench

//  Execute-stage initiator for CSR instructions; the requester side of the CSR-file protocol.

---
 rtl/csr_pkg.sv | 34 +++
 rtl/csr_alu.sv | 22 ++
 rtl/csr_access_ctrl.sv | 161 ++++++++++++++++
 tb/tb_csr_access_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access controller.
package csr_pkg;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  // funct3[1:0] selects the modify operation for both register and immediate forms
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RWAIT,
    ST_WR,
    ST_DONE
  } csr_state_e;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_RW) || (f3 == F3_RS) || (f3 == F3_RC) ||
           (f3 == F3_RWI) || (f3 == F3_RSI) || (f3 == F3_RCI);
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational read-modify-write value for CSRRW/S/C and immediate forms.
module csr_alu
  import csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]            op_sel,
  input  logic [DATA_WIDTH-1:0] old_val,
  input  logic [DATA_WIDTH-1:0] op_val,
  output logic [DATA_WIDTH-1:0] new_val_c
);

  always_comb begin
    new_val_c = op_val;
    case (op_sel)
      OP_RS:   new_val_c = old_val | op_val;
      OP_RC:   new_val_c = old_val & ~op_val;
      default: new_val_c = op_val;
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Execute-stage CSR requester: read/modify/write handshake with pipeline stall.
// Optional CSR_ILLEGAL_CHK_EN: block writes to read-only CSRs and flag illegal_csr.
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_is_csr,
  input  logic [2:0]            ex_funct3,
  input  logic [ADDR_WIDTH-1:0] ex_csr_addr,
  input  logic [4:0]            ex_rs1_idx,
  input  logic [DATA_WIDTH-1:0] ex_rs1_data,
  input  logic [4:0]            ex_rd_idx,
  input  logic                  flush,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_we,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  stall,
  output logic                  rd_we,
  output logic [4:0]            rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
`ifdef CSR_ILLEGAL_CHK_EN
  ,
  output logic                  illegal_csr
`endif
);

  csr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            kind_q;
  logic [4:0]            rd_q;
  logic [DATA_WIDTH-1:0] op_q, old_q, wdata_q;
  logic                  do_write_q, drop_q, illegal_q;

  logic                  issue_c;
  logic [DATA_WIDTH-1:0] op_in;
  logic                  is_rw_in, do_read_in, do_write_in, ill_in;
  logic [DATA_WIDTH-1:0] new_val_c;

  // Instruction decode at issue time
  always_comb begin
    issue_c     = (state_q == ST_IDLE) & ex_valid & ex_is_csr & f3_legal(ex_funct3) & ~flush;
    op_in       = ex_funct3[2] ? DATA_WIDTH'(ex_rs1_idx) : ex_rs1_data;
    is_rw_in    = (ex_funct3[1:0] == OP_RW);
    do_read_in  = ~(is_rw_in & (ex_rd_idx == 5'd0));
    do_write_in = is_rw_in | (ex_rs1_idx != 5'd0);
`ifdef CSR_ILLEGAL_CHK_EN
    ill_in      = do_write_in & (ex_csr_addr[ADDR_WIDTH-1 -: 2] == 2'b11);
`else
    ill_in      = 1'b0;
`endif
  end

  csr_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op_sel    (kind_q),
    .old_val   (rsp_rdata),
    .op_val    (op_q),
    .new_val_c (new_val_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake/stall outputs
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    req_we    = 1'b0;
    stall     = 1'b0;
    rd_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = issue_c;
        if (issue_c) begin
          if (do_read_in)  state_d = ST_RD;
          else if (ill_in) state_d = ST_DONE;
          else             state_d = ST_WR;
        end
      end
      ST_RD: begin
        req_valid = 1'b1;
        stall     = 1'b1;
        if (req_ready)  state_d = ST_RWAIT;
        else if (flush) state_d = ST_IDLE;
      end
      ST_RWAIT: begin
        stall = 1'b1;
        if (rsp_valid) begin
          if (drop_q | flush) state_d = ST_IDLE;
          else if (do_write_q) state_d = ST_WR;
          else                 state_d = ST_DONE;
        end
      end
      ST_WR: begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        stall     = 1'b1;
        if (req_ready)  state_d = ST_DONE;
        else if (flush) state_d = ST_IDLE;
      end
      ST_DONE: begin
        rd_we   = (rd_q != 5'd0) & ~illegal_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latched instruction context and captured CSR data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      kind_q     <= '0;
      rd_q       <= '0;
      op_q       <= '0;
      old_q      <= '0;
      wdata_q    <= '0;
      do_write_q <= 1'b0;
      drop_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if (issue_c) begin
        addr_q     <= ex_csr_addr;
        kind_q     <= ex_funct3[1:0];
        rd_q       <= ex_rd_idx;
        op_q       <= op_in;
        old_q      <= '0;
        wdata_q    <= op_in;
        do_write_q <= do_write_in & ~ill_in;
        drop_q     <= 1'b0;
        illegal_q  <= ill_in;
      end
      // A flushed read that was already accepted still owes a response; discard it later
      if (((state_q == ST_RD) & req_ready & flush) | ((state_q == ST_RWAIT) & flush))
        drop_q <= 1'b1;
      if ((state_q == ST_RWAIT) & rsp_valid & ~(drop_q | flush)) begin
        old_q   <= rsp_rdata;
        wdata_q <= new_val_c;
      end
    end
  end

  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;
  assign rd_idx    = rd_q;
  assign rd_data   = old_q;
`ifdef CSR_ILLEGAL_CHK_EN
  assign illegal_csr = (state_q == ST_DONE) & illegal_q;
`endif

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: directed table, corner sequences, random vs model.
module tb_csr_access_ctrl;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_csr, flush;
  logic [2:0]  ex_funct3;
  logic [11:0] ex_csr_addr;
  logic [4:0]  ex_rs1_idx, ex_rd_idx;
  logic [31:0] ex_rs1_data;
  logic        req_valid, req_ready, req_we;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        stall, rd_we;
  logic [4:0]  rd_idx;
  logic [31:0] rd_data;
`ifdef CSR_ILLEGAL_CHK_EN
  logic        illegal_csr;
`endif

  always #5 clk = ~clk;

  csr_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_csr(ex_is_csr), .ex_funct3(ex_funct3),
    .ex_csr_addr(ex_csr_addr), .ex_rs1_idx(ex_rs1_idx), .ex_rs1_data(ex_rs1_data),
    .ex_rd_idx(ex_rd_idx), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .stall(stall), .rd_we(rd_we), .rd_idx(rd_idx), .rd_data(rd_data)
`ifdef CSR_ILLEGAL_CHK_EN
    , .illegal_csr(illegal_csr)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    int          n_rd;
    int          n_wr;
    logic [11:0] rd_addr;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    int          n_rdwe;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;
    int          lat;
    int          n_ill;
    logic        stable_ok;
    logic        stall_ok;
    logic        tail_ok;
    logic        timeout;
  } obs_t;

  typedef struct packed {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  rs1;
    logic [31:0] rs1d;
    logic [4:0]  rd;
    logic [31:0] old;
    int          rdy;
    int          nrd;
    int          nwr;
    logic [31:0] wd;
    int          nrdwe;
    int          lat;
  } vec_t;

  // Issue one instruction and play a CSR-file responder; records what the DUT did
  task automatic run_instr(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                           input logic [31:0] rs1d, input logic [4:0] rd, input logic [31:0] old,
                           input int rdy_dly, input int rsp_dly, input int flush_cyc,
                           output obs_t o);
    int          wcnt, rsp_at;
    bit          in_req, done;
    logic        h_we;
    logic [11:0] h_addr;
    logic [31:0] h_wd;
    o = '0;
    o.stable_ok = 1'b1;
    o.stall_ok  = 1'b1;
    rsp_at = -1; in_req = 0; done = 0; wcnt = rdy_dly;
    h_we = 1'b0; h_addr = '0; h_wd = '0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        ex_valid = 1'b1; ex_is_csr = 1'b1; ex_funct3 = f3; ex_csr_addr = addr;
        ex_rs1_idx = rs1; ex_rs1_data = rs1d; ex_rd_idx = rd;
      end
      if (k == flush_cyc) begin flush = 1'b1; ex_valid = 1'b0; end
      else flush = 1'b0;
      rsp_valid = (k == rsp_at);
      rsp_rdata = (k == rsp_at) ? old : 32'($urandom);
      req_ready = 1'b0;
      if (req_valid) begin
        if (wcnt == 0) req_ready = 1'b1;
        else wcnt--;
      end
      #1;
      if (req_valid) begin
        if (!in_req) begin
          in_req = 1; h_we = req_we; h_addr = req_addr; h_wd = req_wdata;
        end else if (req_we !== h_we || req_addr !== h_addr || req_wdata !== h_wd) begin
          o.stable_ok = 1'b0;
        end
        if (req_ready) begin
          in_req = 0; wcnt = rdy_dly;
          if (req_we) begin o.n_wr++; o.wr_addr = req_addr; o.wr_data = req_wdata; end
          else begin o.n_rd++; o.rd_addr = req_addr; rsp_at = k + 1 + rsp_dly; end
        end
      end
      if (rd_we) begin o.n_rdwe++; o.rd_idx = rd_idx; o.rd_data = rd_data; end
`ifdef CSR_ILLEGAL_CHK_EN
      if (illegal_csr) o.n_ill++;
`endif
      if (k == 0 && !stall) o.stall_ok = 1'b0;
      if (k >= 1 && !stall) begin o.lat = k; done = 1; break; end
    end
    if (!done) o.timeout = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0; flush = 1'b0; rsp_valid = 1'b0; req_ready = 1'b0;
    #1;
    o.tail_ok = !rd_we && !req_valid && !stall;
  endtask

  task automatic compare(input string tag, input obs_t o, input logic [11:0] addr, input logic [4:0] rd,
                         input int nrd, input int nwr, input logic [31:0] wd, input int nrdwe,
                         input logic [31:0] rdd, input int lat, input int nill);
    chk({tag, " timeout"}, 64'(o.timeout), 64'd0);
    chk({tag, " reads"}, 64'(o.n_rd), 64'(nrd));
    chk({tag, " writes"}, 64'(o.n_wr), 64'(nwr));
    if (nrd > 0) chk({tag, " read addr"}, 64'(o.rd_addr), 64'(addr));
    if (nwr > 0) begin
      chk({tag, " write addr"}, 64'(o.wr_addr), 64'(addr));
      chk({tag, " write data"}, 64'(o.wr_data), 64'(wd));
    end
    chk({tag, " rd_we pulses"}, 64'(o.n_rdwe), 64'(nrdwe));
    if (nrdwe > 0) begin
      chk({tag, " rd_idx"}, 64'(o.rd_idx), 64'(rd));
      chk({tag, " rd_data"}, 64'(o.rd_data), 64'(rdd));
    end
    chk({tag, " latency"}, 64'(o.lat), 64'(lat));
    chk({tag, " req stable"}, 64'(o.stable_ok), 64'd1);
    chk({tag, " issue stall"}, 64'(o.stall_ok), 64'd1);
    chk({tag, " idle after"}, 64'(o.tail_ok), 64'd1);
`ifdef CSR_ILLEGAL_CHK_EN
    chk({tag, " illegal pulses"}, 64'(o.n_ill), 64'(nill));
`else
    if (nill != 0) chk({tag, " illegal model"}, 64'(nill), 64'd0);
`endif
  endtask

  // Transaction-level reference: what a CSR instruction must do to the CSR file and rd
  task automatic model(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                       input logic [31:0] rs1d, input logic [4:0] rd, input logic [31:0] old,
                       input int rdy, input int rsp,
                       output int nrd, output int nwr, output logic [31:0] wd,
                       output int nrdwe, output int lat, output int nill);
    logic [31:0] op;
    bit rw, does_read, does_write, ill;
    op = f3[2] ? {27'd0, rs1} : rs1d;
    rw = (f3[1:0] == 2'b01);
    does_read  = !(rw && rd == 5'd0);
    does_write = rw || (rs1 != 5'd0);
    ill = 0;
`ifdef CSR_ILLEGAL_CHK_EN
    if (does_write && addr[11:10] == 2'b11) begin ill = 1; does_write = 0; end
`endif
    if (rw) wd = op;
    else if (f3[1:0] == 2'b10) wd = old | op;
    else wd = old & ~op;
    nrd   = does_read ? 1 : 0;
    nwr   = does_write ? 1 : 0;
    nrdwe = (does_read && rd != 5'd0 && !ill) ? 1 : 0;
    nill  = ill ? 1 : 0;
    lat   = 1 + (does_read ? 2 + rdy + rsp : 0) + (does_write ? 1 + rdy : 0);
  endtask

  vec_t        vecs [8];
  logic [31:0] csr_mem [logic [11:0]];
  logic [2:0]  f3_pool [6];
  logic [11:0] addr_pool [8];

  initial begin
    obs_t o;
    int nrd, nwr, nrdwe, lat, nill;
    logic [31:0] wd;

    vecs[0] = '{F3_RS,  12'hC00, 5'd0,  32'h0,         5'd5,  32'h64,        0, 1, 0, 32'h0,        1, 3};
    vecs[1] = '{F3_RW,  12'h300, 5'd7,  32'hA5,        5'd0,  32'h1234,      0, 0, 1, 32'hA5,       0, 2};
    vecs[2] = '{F3_RCI, 12'h300, 5'd3,  32'h0,         5'd3,  32'hFF,        0, 1, 1, 32'hFC,       1, 4};
    vecs[3] = '{F3_RS,  12'h305, 5'd6,  32'h0F00,      5'd10, 32'h00F0,      5, 1, 1, 32'h0FF0,     1, 14};
    vecs[4] = '{F3_RWI, 12'h340, 5'h1F, 32'h0,         5'd2,  32'hDEADBEEF,  0, 1, 1, 32'h1F,       1, 4};
    vecs[5] = '{F3_RSI, 12'h341, 5'd0,  32'h0,         5'd9,  32'h55,        0, 1, 0, 32'h0,        1, 3};
    vecs[6] = '{F3_RC,  12'h300, 5'd4,  32'hFFFF0000,  5'd0,  32'h12345678,  0, 1, 1, 32'h00005678, 0, 4};
    vecs[7] = '{F3_RW,  12'h300, 5'd0,  32'h0,         5'd1,  32'h77,        0, 1, 1, 32'h0,        1, 4};
    f3_pool   = '{F3_RW, F3_RS, F3_RC, F3_RWI, F3_RSI, F3_RCI};
    addr_pool = '{CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH,
                  12'h300, 12'h305, 12'h340, 12'h341};

    rst = 1'b1; ex_valid = 0; ex_is_csr = 0; ex_funct3 = 0; ex_csr_addr = 0;
    ex_rs1_idx = 0; ex_rs1_data = 0; ex_rd_idx = 0; flush = 0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset outputs", {req_valid, req_we, stall, rd_we, req_addr, rd_idx},  64'd0);
    chk("reset data", {req_wdata, rd_data}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_instr(vecs[i].f3, vecs[i].addr, vecs[i].rs1, vecs[i].rs1d, vecs[i].rd, vecs[i].old,
                vecs[i].rdy, 0, -1, o);
      compare($sformatf("vec%0d", i), o, vecs[i].addr, vecs[i].rd, vecs[i].nrd, vecs[i].nwr,
              vecs[i].wd, vecs[i].nrdwe, vecs[i].old, vecs[i].lat, 0);
    end

    // Flush in RWAIT, response two cycles later: dropped
    run_instr(F3_RS, 12'h300, 5'd6, 32'h1, 5'd5, 32'h10, 0, 2, 2, o);
    compare("flush rwait", o, 12'h300, 5'd5, 1, 0, 32'h0, 0, 32'h0, 5, 0);
    // Flush in RD before accept
    run_instr(F3_RS, 12'h300, 5'd6, 32'h1, 5'd5, 32'h10, 3, 0, 2, o);
    compare("flush rd", o, 12'h300, 5'd5, 0, 0, 32'h0, 0, 32'h0, 3, 0);
    // Flush in WR before accept
    run_instr(F3_RW, 12'h300, 5'd7, 32'h9, 5'd0, 32'h10, 3, 0, 2, o);
    compare("flush wr", o, 12'h300, 5'd0, 0, 0, 32'h0, 0, 32'h0, 3, 0);
    // Flush in DONE is ignored
    run_instr(F3_RS, 12'h341, 5'd0, 32'h0, 5'd8, 32'h42, 0, 0, 3, o);
    compare("flush done", o, 12'h341, 5'd8, 1, 0, 32'h0, 1, 32'h42, 3, 0);

    // funct3 000/100, non-CSR opcode and a stray response: no stall, no request
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_is_csr = (i != 2); ex_funct3 = (i == 0) ? 3'b000 : (i == 1) ? 3'b100 : F3_RW;
      ex_csr_addr = 12'h300; ex_rs1_idx = 5'd1; ex_rd_idx = 5'd1;
      rsp_valid = 1'b1; rsp_rdata = 32'hBAD;
      #1;
      chk($sformatf("ignored f3 case%0d", i), {stall, req_valid, rd_we}, 64'd0);
    end
    @(posedge clk); #1; ex_valid = 0; rsp_valid = 0;

    // Reset mid-operation returns to IDLE at once
    @(posedge clk); #1;
    ex_valid = 1; ex_is_csr = 1; ex_funct3 = F3_RS; ex_csr_addr = 12'h305;
    ex_rs1_idx = 5'd2; ex_rs1_data = 32'h3; ex_rd_idx = 5'd4; req_ready = 0;
    @(posedge clk); #1;
    chk("pre-reset in RD", 64'(req_valid), 64'd1);
    rst = 1'b1; ex_valid = 0;
    #1;
    chk("mid-op reset", {req_valid, stall, rd_we, rd_data}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #2;
    chk("after reset idle", {req_valid, stall, rd_we}, 64'd0);

    // Randomized instructions against the transaction model
    for (int t = 0; t < 150; t++) begin
      logic [2:0]  f3;
      logic [11:0] addr;
      logic [4:0]  rs1, rd;
      logic [31:0] rs1d, old;
      int          rdy, rsp;
      f3   = f3_pool[$urandom_range(0, 5)];
      addr = addr_pool[$urandom_range(0, 7)];
      rs1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rs1d = 32'($urandom);
      rdy  = $urandom_range(0, 3);
      rsp  = $urandom_range(0, 2);
      if (!csr_mem.exists(addr)) csr_mem[addr] = 32'($urandom);
      old = csr_mem[addr];
      model(f3, addr, rs1, rs1d, rd, old, rdy, rsp, nrd, nwr, wd, nrdwe, lat, nill);
      run_instr(f3, addr, rs1, rs1d, rd, old, rdy, rsp, -1, o);
      compare($sformatf("rand%0d", t), o, addr, rd, nrd, nwr, wd, nrdwe, old, lat, nill);
      if (nwr > 0) csr_mem[addr] = wd;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
